// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-beat downstream memory port between the core's
// instruction bus (ibus, fetch) and data bus (dbus, memory stage).
// A single requester owns the port from grant to mresp_data_ok. Its request
// fields are latched at grant, responses are steered back to it only, and the
// other requester sees nothing until its own turn.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin between ibus/dbus when both
//                               request in IDLE (last_grant register built)
//                  undefined -> fixed dbus priority in IDLE
module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,

  // instruction bus
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,

  // data bus
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,

  // downstream memory port
  output logic              mreq_valid,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_addr_ok,
  input  logic              mresp_data_ok,
  input  logic [DATA_W-1:0] mresp_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;

  // Fetches are always 4-byte reads.
  localparam logic [2:0] IBUS_SIZE = 3'b010;

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [2:0]        size_q,    size_d;
  logic [7:0]        strobe_q,  strobe_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic              abandon_q, abandon_d;

`ifdef MEM_ARB_RR_EN
  // 0 = ibus was granted last, 1 = dbus was granted last.
  logic              last_grant_q, last_grant_d;
`endif

  // ---------------------------------------------------------------------------
  // Decoded view of the current owner
  // ---------------------------------------------------------------------------
  logic gnt_i;
  logic gnt_d;
  logic owner_valid;
  logic owner_live;
  logic served_done;
  logic arb_window;

  // Decode owner, whether it is still listening, and whether an arbitration
  // decision is taken at the coming edge (in IDLE or on completion).
  always_comb begin
    gnt_i       = (state_q == ST_GNT_I);
    gnt_d       = (state_q == ST_GNT_D);
    owner_valid = (gnt_i & ireq_valid) | (gnt_d & dreq_valid);
    // A requester that dropped valid (now or earlier in this transaction)
    // gets no further handshakes for it.
    owner_live  = owner_valid & ~abandon_q;
    served_done = (gnt_i | gnt_d) & mresp_data_ok;
    arb_window  = (state_q == ST_IDLE) | served_done;
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic cand_i;
  logic cand_d;
  logic pick_i;
  logic pick_d;

  // Choose the next owner. The requester just served is excluded, so on
  // completion the other one is handed the port directly if it is waiting.
  always_comb begin
    cand_i = ireq_valid & ~gnt_i;
    cand_d = dreq_valid & ~gnt_d;
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (arb_window) begin
      if (cand_i && cand_d) begin
        // Both can only be candidates in IDLE.
`ifdef MEM_ARB_RR_EN
        pick_i = last_grant_q;
        pick_d = ~last_grant_q;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_i = cand_i;
        pick_d = cand_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, request latch and abandon tracking
  // ---------------------------------------------------------------------------

  // Compute the next owner and capture the winner's request fields at grant.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    strobe_d  = strobe_q;
    data_d    = data_q;
    abandon_d = abandon_q;
    if (arb_window) begin
      abandon_d = 1'b0;
      if (pick_d) begin
        state_d  = ST_GNT_D;
        addr_d   = dreq_addr;
        size_d   = dreq_size;
        strobe_d = dreq_strobe;
        data_d   = dreq_data;
      end else if (pick_i) begin
        state_d  = ST_GNT_I;
        addr_d   = ireq_addr;
        size_d   = IBUS_SIZE;
        strobe_d = 8'h00;
        data_d   = {DATA_W{1'b0}};
      end else begin
        state_d  = ST_IDLE;
      end
    end else if (!owner_valid) begin
      // Owner gave up; the downstream beat still finishes (a store must land),
      // but its handshakes are swallowed from now on.
      abandon_d = 1'b1;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember who was granted last, updated on every grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (pick_d) begin
      last_grant_d = 1'b1;
    end else if (pick_i) begin
      last_grant_d = 1'b0;
    end
  end
`endif

  // State registers; reset returns to IDLE at once, dropping mreq_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      strobe_q  <= '0;
      data_q    <= '0;
      abandon_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      strobe_q  <= strobe_d;
      data_q    <= data_d;
      abandon_q <= abandon_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Downstream request: purely from registers, never from requester inputs
  // ---------------------------------------------------------------------------
  assign mreq_valid  = (state_q != ST_IDLE);
  assign mreq_addr   = addr_q;
  assign mreq_size   = size_q;
  assign mreq_strobe = strobe_q;
  assign mreq_data   = data_q;

  // ---------------------------------------------------------------------------
  // Response steering
  // ---------------------------------------------------------------------------
  logic [31:0] ibus_word;

  // Route handshakes to the live owner only; data buses are zero unless their
  // data_ok is high. The ibus word is picked by address bit 2 of the fetch.
  always_comb begin
    iresp_addr_ok = gnt_i & owner_live & mresp_addr_ok;
    iresp_data_ok = gnt_i & owner_live & mresp_data_ok;
    dresp_addr_ok = gnt_d & owner_live & mresp_addr_ok;
    dresp_data_ok = gnt_d & owner_live & mresp_data_ok;

    ibus_word     = addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];
    iresp_data    = iresp_data_ok ? ibus_word : 32'h0;
    dresp_data    = dresp_data_ok ? mresp_data : {DATA_W{1'b0}};
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with a transaction-level ownership model
// checked every cycle, a simple latency-programmable downstream memory, and
// hand-computed literal expectations for the key scenarios.
// Honours MEM_ARB_RR_EN in the model when the build defines it.
module tb_mem_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;

  logic          ireq_valid;
  logic [AW-1:0] ireq_addr;
  logic          iresp_addr_ok;
  logic          iresp_data_ok;
  logic [31:0]   iresp_data;

  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [DW-1:0] dreq_data;
  logic          dresp_addr_ok;
  logic          dresp_data_ok;
  logic [DW-1:0] dresp_data;

  logic          mreq_valid;
  logic [AW-1:0] mreq_addr;
  logic [2:0]    mreq_size;
  logic [7:0]    mreq_strobe;
  logic [DW-1:0] mreq_data;
  logic          mresp_addr_ok;
  logic          mresp_data_ok;
  logic [DW-1:0] mresp_data;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .mreq_valid    (mreq_valid),
    .mreq_addr     (mreq_addr),
    .mreq_size     (mreq_size),
    .mreq_strobe   (mreq_strobe),
    .mreq_data     (mreq_data),
    .mresp_addr_ok (mresp_addr_ok),
    .mresp_data_ok (mresp_data_ok),
    .mresp_data    (mresp_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int mem_lat = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream memory contents as seen by reads.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0004) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Ownership model: who holds the port (0 none, 1 ibus, 2 dbus), the request
  // it was granted with, and whether it walked away.
  // ---------------------------------------------------------------------------
  int          m_owner  = 0;
  int          m_last   = 1;
  bit          m_aband  = 1'b0;
  logic [63:0] m_addr   = '0;
  logic [2:0]  m_size   = '0;
  logic [7:0]  m_strobe = '0;
  logic [63:0] m_data   = '0;

  function automatic int model_pick(input bit want_i, input bit want_d, input int last);
    if (want_i && want_d) begin
`ifdef MEM_ARB_RR_EN
      return (last == 2) ? 1 : 2;
`else
      return 2;
`endif
    end
    if (want_d) return 2;
    if (want_i) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    int w;
    if (!reset) begin
      m_owner  <= 0;
      m_last   <= 1;
      m_aband  <= 1'b0;
      m_addr   <= '0;
      m_size   <= '0;
      m_strobe <= '0;
      m_data   <= '0;
    end else if (m_owner == 0 || mresp_data_ok) begin
      w = model_pick(ireq_valid && m_owner != 1, dreq_valid && m_owner != 2, m_last);
      m_owner <= w;
      m_aband <= 1'b0;
      if (w == 1) begin
        m_addr <= ireq_addr; m_size <= 3'b010; m_strobe <= 8'h00; m_data <= '0; m_last <= 1;
      end else if (w == 2) begin
        m_addr <= dreq_addr; m_size <= dreq_size; m_strobe <= dreq_strobe; m_data <= dreq_data;
        m_last <= 2;
      end
    end else if (!((m_owner == 1) ? ireq_valid : dreq_valid)) begin
      m_aband <= 1'b1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    bit live;
    logic [31:0] exp_iw;
    if (chk_en) begin
      live = !m_aband && ((m_owner == 1 && ireq_valid) || (m_owner == 2 && dreq_valid));
      check("mdl_mreq_valid", mreq_valid, m_owner != 0);
      if (m_owner != 0) begin
        check("mdl_mreq_addr",   mreq_addr,   m_addr);
        check("mdl_mreq_size",   mreq_size,   m_size);
        check("mdl_mreq_strobe", mreq_strobe, m_strobe);
        check("mdl_mreq_data",   mreq_data,   m_data);
      end
      check("mdl_iresp_addr_ok", iresp_addr_ok, m_owner == 1 && live && mresp_addr_ok);
      check("mdl_iresp_data_ok", iresp_data_ok, m_owner == 1 && live && mresp_data_ok);
      check("mdl_dresp_addr_ok", dresp_addr_ok, m_owner == 2 && live && mresp_addr_ok);
      check("mdl_dresp_data_ok", dresp_data_ok, m_owner == 2 && live && mresp_data_ok);
      exp_iw = m_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
      check("mdl_iresp_data", iresp_data,
            (m_owner == 1 && live && mresp_data_ok) ? exp_iw : 32'h0);
      check("mdl_dresp_data", dresp_data,
            (m_owner == 2 && live && mresp_data_ok) ? mresp_data : 64'h0);
    end
  end

  // ---------------------------------------------------------------------------
  // Downstream memory: addr_ok on the first cycle of a request, data_ok after
  // mem_lat cycles of mreq_valid; garbage on mresp_data otherwise.
  // ---------------------------------------------------------------------------
  int mcnt = 0;
  initial begin
    mresp_addr_ok = 1'b0;
    mresp_data_ok = 1'b0;
    mresp_data    = 64'hDEAD_BEEF_0BAD_F00D;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        mcnt = 0;
        mresp_addr_ok = 1'b0;
        mresp_data_ok = 1'b0;
        mresp_data    = 64'hDEAD_BEEF_0BAD_F00D;
      end else begin
        if (mresp_data_ok) mcnt = 0;
        if (mreq_valid) mcnt++;
        else            mcnt = 0;
        mresp_addr_ok = mreq_valid && (mcnt == 1);
        mresp_data_ok = mreq_valid && (mcnt == mem_lat);
        mresp_data    = mresp_data_ok ? mem_word(mreq_addr) : 64'hDEAD_BEEF_0BAD_F00D;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after posedge, samples at negedge
  // ---------------------------------------------------------------------------
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic bit cur(input int which);
    case (which)
      0:       return iresp_data_ok;
      1:       return dresp_data_ok;
      default: return mresp_data_ok;
    endcase
  endfunction

  // Advance cycle by cycle until the chosen strobe is seen at a sample point.
  task automatic wait_sig(input int which, input int budget, input string name, output int waited);
    waited = 0;
    while (!cur(which)) begin
      if (waited >= budget) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout after %0d cycles, got no strobe, expected one", name, waited);
        return;
      end
      drive_edge();
      sample();
      waited++;
    end
  endtask

  initial begin
    int  w;
    bit  was_i;
    int  n_done;
    logic [63:0] a;

    ireq_valid = 0; ireq_addr = 0;
    dreq_valid = 0; dreq_addr = 0; dreq_size = 0; dreq_strobe = 0; dreq_data = 0;

    // Reset state
    reset = 1'b0;
    drive_edge();
    chk_en = 1'b1;
    sample();
    check("rst_mreq_valid", mreq_valid, 0);
    check("rst_mreq_addr", mreq_addr, 0);
    check("rst_iresp_data_ok", iresp_data_ok, 0);
    check("rst_dresp_data", dresp_data, 0);
    drive_edge();
    reset = 1'b1;
    sample();

    // Single fetch at 0x8000_0004, memory latency 3
    mem_lat = 3;
    drive_edge();
    ireq_valid = 1; ireq_addr = 64'h8000_0004;
    sample();
    check("t1_no_comb_grant", mreq_valid, 0);
    drive_edge();
    sample();
    check("t1_mreq_valid_c1", mreq_valid, 1);
    check("t1_mreq_addr", mreq_addr, 64'h8000_0004);
    check("t1_mreq_size", mreq_size, 3'b010);
    check("t1_iresp_addr_ok", iresp_addr_ok, 1);
    wait_sig(0, 10, "t1_wait_iresp", w);
    check("t1_data_cycle", w, 2);
    check("t1_iresp_data", iresp_data, 32'hAAAA_BBBB);
    drive_edge();
    ireq_valid = 0;
    sample();
    check("t1_idle_after", mreq_valid, 0);

    // Simultaneous ireq + dreq load in IDLE: dbus first, ibus handed over
    drive_edge();
    ireq_valid = 1; ireq_addr = 64'h8000_0100;
    dreq_valid = 1; dreq_addr = 64'h8000_1000; dreq_size = 3'b011; dreq_strobe = 0; dreq_data = 0;
    sample();
    drive_edge();
    sample();
    check("t2_first_is_d", mreq_addr, 64'h8000_1000);
    wait_sig(1, 10, "t2_wait_dresp", w);
    check("t2_dresp_data", dresp_data, 64'hDA5A_1000_7FFF_EFFF);
    drive_edge();
    dreq_valid = 0;
    sample();
    check("t2_no_bubble_valid", mreq_valid, 1);
    check("t2_no_bubble_addr", mreq_addr, 64'h8000_0100);
    wait_sig(0, 10, "t2_wait_iresp", w);
    check("t2_iresp_data", iresp_data, 32'h7FFF_FEFF);
    drive_edge();
    ireq_valid = 0;
    sample();

    // Lone dbus load so the dbus was granted last, then both together
    drive_edge();
    dreq_valid = 1; dreq_addr = 64'h8000_1008;
    sample();
    wait_sig(1, 10, "t2b_wait_dresp", w);
    drive_edge();
    dreq_valid = 0;
    sample();
    drive_edge();
    ireq_valid = 1; ireq_addr = 64'h8000_0200;
    dreq_valid = 1; dreq_addr = 64'h8000_1010;
    sample();
    drive_edge();
    sample();
`ifdef MEM_ARB_RR_EN
    check("t2b_first_grant", mreq_addr, 64'h8000_0200);
`else
    check("t2b_first_grant", mreq_addr, 64'h8000_1010);
`endif
    wait_sig(2, 10, "t2b_wait_first", w);
    was_i = iresp_data_ok;
    drive_edge();
    if (was_i) ireq_valid = 0;
    else       dreq_valid = 0;
    sample();
    wait_sig(2, 10, "t2b_wait_second", w);
    drive_edge();
    ireq_valid = 0; dreq_valid = 0;
    sample();

    // Store while ibus toggles its address: latch holds, ibus sees nothing
    mem_lat = 4;
    drive_edge();
    dreq_valid = 1; dreq_addr = 64'h8000_2000; dreq_size = 3'b011;
    dreq_strobe = 8'hF0; dreq_data = 64'h1122_3344_5566_7788;
    sample();
    drive_edge();
    ireq_valid = 1; ireq_addr = 64'h8000_0300;
    dreq_addr = 64'h0; dreq_strobe = 8'h0F; dreq_data = 64'h0;
    sample();
    w = 0;
    while (!dresp_data_ok && w < 10) begin
      check("t3_mreq_addr", mreq_addr, 64'h8000_2000);
      check("t3_mreq_strobe", mreq_strobe, 8'hF0);
      check("t3_mreq_data", mreq_data, 64'h1122_3344_5566_7788);
      check("t3_iresp_addr_ok", iresp_addr_ok, 0);
      check("t3_iresp_data_ok", iresp_data_ok, 0);
      drive_edge();
      ireq_addr = ireq_addr ^ 64'h40;
      sample();
      w++;
    end
    check("t3_store_done", dresp_data_ok, 1);
    check("t3_iresp_during_done", iresp_data_ok, 0);
    drive_edge();
    dreq_valid = 0;
    sample();
    check("t3_handover_valid", mreq_valid, 1);
    wait_sig(0, 10, "t3_wait_iresp", w);
    drive_edge();
    ireq_valid = 0;
    sample();

    // Abandon: dbus drops valid one cycle after grant
    drive_edge();
    dreq_valid = 1; dreq_addr = 64'h8000_3000; dreq_strobe = 8'h00; dreq_data = 0;
    sample();
    drive_edge();
    sample();
    check("t4_addr_ok_before_drop", dresp_addr_ok, 1);
    drive_edge();
    dreq_valid = 0;
    sample();
    w = 0;
    while (!mresp_data_ok && w < 10) begin
      check("t4_mreq_held", mreq_valid, 1);
      check("t4_dresp_data_ok", dresp_data_ok, 0);
      drive_edge();
      sample();
      w++;
    end
    check("t4_downstream_done", mresp_data_ok, 1);
    check("t4_dresp_suppressed", dresp_data_ok, 0);
    check("t4_dresp_data_zero", dresp_data, 0);
    drive_edge();
    sample();
    check("t4_idle_after", mreq_valid, 0);

    // Reset asserted during GNT_I with a response pending
    mem_lat = 3;
    drive_edge();
    ireq_valid = 1; ireq_addr = 64'h8000_0008;
    sample();
    drive_edge();
    sample();
    check("t5_granted", mreq_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_mreq_valid_async", mreq_valid, 0);
    check("t5_mreq_addr_clr", mreq_addr, 0);
    check("t5_iresp_addr_ok", iresp_addr_ok, 0);
    check("t5_iresp_data", iresp_data, 0);
    ireq_valid = 0;
    drive_edge();
    drive_edge();
    reset = 1'b1;
    sample();
    check("t5_idle_after_reset", mreq_valid, 0);

    // Eight back-to-back fetches with ireq_valid held: one IDLE cycle each
    mem_lat = 1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      drive_edge();
      ireq_valid = 1;
      ireq_addr  = 64'h8000_0400 + 64'(4 * k);
      sample();
      check("t6_bubble", mreq_valid, 0);
      wait_sig(0, 5, "t6_wait_iresp", w);
      a = mem_word(ireq_addr);
      check("t6_iresp_data", iresp_data, (k % 2 == 1) ? a[63:32] : a[31:0]);
      if (iresp_data_ok) n_done++;
    end
    drive_edge();
    ireq_valid = 0;
    sample();
    check("t6_fetch_count", n_done, 8);

    drive_edge();
    drive_edge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
